// File: rtl/traffic_sink.sv
// traffic_sink: receive-side NoC endpoint. Accepts every ejected flit,
// returns one credit per flit on its VC, follows each VC's packet from
// header to tail and reports source, class, distance, size and latencies
// one cycle after the tail is sampled.
module traffic_sink #(
    parameter int    V            = 4,
    parameter int    NX           = 4,
    parameter int    NY           = 4,
    parameter int    Fpay         = 32,
    parameter int    C            = 4,
    parameter string TOPOLOGY     = "MESH",
    parameter int    MAX_PCK_NUM  = 10000,
    parameter int    MAX_SIM_CLKs = 100000,
    parameter int    MAX_PCK_SIZ  = 16,
    localparam int   Xw       = ($clog2(NX) < 1) ? 1 : $clog2(NX),
    localparam int   Yw       = ($clog2(NY) < 1) ? 1 : $clog2(NY),
    localparam int   Cw       = (C > 1) ? (($clog2(C) < 1) ? 1 : $clog2(C)) : 1,
    localparam int   Fw       = 2 + V + Fpay,
    localparam int   CLK_CNTw = ($clog2(MAX_SIM_CLKs + 1) < 1) ? 1 : $clog2(MAX_SIM_CLKs + 1),
    localparam int   PCK_SIZw = ($clog2(MAX_PCK_SIZ + 1) < 1) ? 1 : $clog2(MAX_PCK_SIZ + 1),
    localparam int   PCK_CNTw = ($clog2(MAX_PCK_NUM + 1) < 1) ? 1 : $clog2(MAX_PCK_NUM + 1),
    localparam int   NC       = ((TOPOLOGY == "RING") || (TOPOLOGY == "LINE")) ? NX : NX * NY,
    localparam int   DSTw     = ($clog2(NC + 1) < 1) ? 1 : $clog2(NC + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [Xw-1:0]       current_x,
    input  logic [Yw-1:0]       current_y,
    input  logic [Fw-1:0]       flit_in,
    input  logic                flit_in_wr,
    output logic [V-1:0]        credit_out,
    output logic                update,
    output logic [Xw-1:0]       src_x,
    output logic [Yw-1:0]       src_y,
    output logic [Cw-1:0]       pck_class_out,
    output logic [DSTw-1:0]     distance,
    output logic [PCK_SIZw-1:0] pck_size_out,
    output logic [CLK_CNTw-1:0] time_stamp_h2h,
    output logic [CLK_CNTw-1:0] time_stamp_h2t,
    output logic [PCK_CNTw-1:0] rcv_pck_number,
    output logic                protocol_err
);

    localparam int  VCw     = ($clog2(V) < 1) ? 1 : $clog2(V);
    localparam int  HDRw    = Xw + Yw + Cw + CLK_CNTw;
    localparam bit  IS_1D   = (TOPOLOGY == "RING") || (TOPOLOGY == "LINE");
    localparam bit  IS_WRAP = (TOPOLOGY == "TORUS") || (TOPOLOGY == "RING");
    localparam logic [PCK_SIZw-1:0] SIZ_MAX = PCK_SIZw'(MAX_PCK_SIZ);
    localparam logic [PCK_CNTw-1:0] CNT_MAX = PCK_CNTw'(MAX_PCK_NUM);

    // The header must carry source, class and injection time.
    if (Fpay < HDRw) begin : g_fpay_check
        $error("traffic_sink: Fpay is too narrow for the header fields");
    end

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} vc_state_t;

    // Hop count from (sx,sy) to (cx,cy) for the configured topology.
    function automatic logic [DSTw-1:0] hop_distance(
        input logic [Xw-1:0] sx, input logic [Yw-1:0] sy,
        input logic [Xw-1:0] cx, input logic [Yw-1:0] cy);
        int dx;
        int dy;
        dx = (sx >= cx) ? int'(sx - cx) : int'(cx - sx);
        dy = (sy >= cy) ? int'(sy - cy) : int'(cy - sy);
        if (IS_WRAP && ((NX - dx) < dx)) dx = NX - dx;
        if (IS_1D) dy = 0;
        else if ((TOPOLOGY == "TORUS") && ((NY - dy) < dy)) dy = NY - dy;
        return DSTw'(dx + dy);
    endfunction

    // Size increment that sticks at the configured maximum.
    function automatic logic [PCK_SIZw-1:0] size_inc(input logic [PCK_SIZw-1:0] s);
        return (s >= SIZ_MAX) ? SIZ_MAX : s + PCK_SIZw'(1);
    endfunction

    // Flit fields
    logic                w_is_hdr;
    logic                w_is_tail;
    logic [V-1:0]        w_vc_field;
    logic                w_vc_onehot;
    logic [VCw-1:0]      w_vc_idx;
    logic [Xw-1:0]       w_hdr_sx;
    logic [Yw-1:0]       w_hdr_sy;
    logic [Cw-1:0]       w_hdr_cls;
    logic [CLK_CNTw-1:0] w_hdr_ts;
    logic                w_unused;

    assign w_is_hdr    = flit_in[Fw-1];
    assign w_is_tail   = flit_in[Fw-2];
    assign w_vc_field  = flit_in[Fpay+V-1:Fpay];
    assign w_vc_onehot = $onehot(w_vc_field);
    assign w_hdr_sx    = flit_in[Xw-1:0];
    assign w_hdr_sy    = flit_in[Xw+Yw-1:Xw];
    assign w_hdr_cls   = flit_in[Xw+Yw +: Cw];
    assign w_hdr_ts    = flit_in[Xw+Yw+Cw +: CLK_CNTw];

    if (Fpay > HDRw) begin : g_spare_bits
        assign w_unused = ^flit_in[Fpay-1:HDRw];
    end else begin : g_no_spare_bits
        assign w_unused = 1'b0;
    end

    // State and per-VC packet registers
    logic [CLK_CNTw-1:0] r_clk_cnt;
    vc_state_t           r_state      [V];
    vc_state_t           w_state_next [V];
    logic [Xw-1:0]       r_vc_sx      [V];
    logic [Yw-1:0]       r_vc_sy      [V];
    logic [Cw-1:0]       r_vc_cls     [V];
    logic [CLK_CNTw-1:0] r_vc_inj     [V];
    logic [CLK_CNTw-1:0] r_vc_hdr     [V];
    logic [PCK_SIZw-1:0] r_vc_size    [V];

    logic [V-1:0]        w_capture;
    logic [V-1:0]        w_grow;
    logic                w_done_multi;
    logic                w_done_single;
    logic                w_done;
    logic                w_err;

    // Completed-packet values
    logic [Xw-1:0]       w_cmp_sx;
    logic [Yw-1:0]       w_cmp_sy;
    logic [Cw-1:0]       w_cmp_cls;
    logic [PCK_SIZw-1:0] w_cmp_size;
    logic [CLK_CNTw-1:0] w_cmp_h2h;
    logic [CLK_CNTw-1:0] w_cmp_h2t;
    logic [DSTw-1:0]     w_cmp_dist;

    // Output registers
    logic [V-1:0]        r_credit;
    logic                r_update;
    logic [Xw-1:0]       r_src_x;
    logic [Yw-1:0]       r_src_y;
    logic [Cw-1:0]       r_class;
    logic [DSTw-1:0]     r_dist;
    logic [PCK_SIZw-1:0] r_size;
    logic [CLK_CNTw-1:0] r_h2h;
    logic [CLK_CNTw-1:0] r_h2t;
    logic [PCK_CNTw-1:0] r_rcv_cnt;
    logic                r_err;

    // Convert the one-hot VC field to an index (meaningful only when one-hot).
    always_comb begin
        w_vc_idx = {VCw{1'b0}};
        for (int i = 0; i < V; i++) begin
            if (w_vc_field[i]) w_vc_idx = VCw'(i);
            else               w_vc_idx = w_vc_idx;
        end
    end

    // Per-VC packet tracking: next state, capture/grow strobes, completion and errors.
    always_comb begin
        for (int i = 0; i < V; i++) w_state_next[i] = r_state[i];
        w_capture     = {V{1'b0}};
        w_grow        = {V{1'b0}};
        w_done_multi  = 1'b0;
        w_done_single = 1'b0;
        w_err         = 1'b0;
        if (flit_in_wr) begin
            if (w_vc_onehot) begin
                case (r_state[w_vc_idx])
                    ST_IDLE: begin
                        if (w_is_hdr) begin
                            if (w_is_tail) begin
                                w_done_single = 1'b1;
                            end else begin
                                w_capture[w_vc_idx]    = 1'b1;
                                w_state_next[w_vc_idx] = ST_BUSY;
                            end
                        end else begin
                            // body/tail with no open packet is dropped
                            w_err = 1'b1;
                        end
                    end
                    ST_BUSY: begin
                        if (w_is_hdr) begin
                            // new header abandons the open packet without a report
                            w_err = 1'b1;
                            if (w_is_tail) begin
                                w_done_single          = 1'b1;
                                w_state_next[w_vc_idx] = ST_IDLE;
                            end else begin
                                w_capture[w_vc_idx]    = 1'b1;
                                w_state_next[w_vc_idx] = ST_BUSY;
                            end
                        end else begin
                            w_grow[w_vc_idx] = 1'b1;
                            if (w_is_tail) begin
                                w_done_multi           = 1'b1;
                                w_state_next[w_vc_idx] = ST_IDLE;
                            end else begin
                                w_state_next[w_vc_idx] = ST_BUSY;
                            end
                        end
                    end
                    default: begin
                        w_err = 1'b1;
                    end
                endcase
            end else begin
                w_err = 1'b1;
            end
        end else begin
            w_err = 1'b0;
        end
    end

    assign w_done = w_done_single | w_done_multi;

    // Select the report fields from either the live header flit or the VC's saved header.
    always_comb begin
        if (w_done_single) begin
            w_cmp_sx   = w_hdr_sx;
            w_cmp_sy   = w_hdr_sy;
            w_cmp_cls  = w_hdr_cls;
            w_cmp_size = PCK_SIZw'(1);
            w_cmp_h2h  = r_clk_cnt - w_hdr_ts;
            w_cmp_h2t  = r_clk_cnt - w_hdr_ts;
        end else begin
            w_cmp_sx   = r_vc_sx[w_vc_idx];
            w_cmp_sy   = r_vc_sy[w_vc_idx];
            w_cmp_cls  = r_vc_cls[w_vc_idx];
            w_cmp_size = size_inc(r_vc_size[w_vc_idx]);
            w_cmp_h2h  = r_vc_hdr[w_vc_idx] - r_vc_inj[w_vc_idx];
            w_cmp_h2t  = r_clk_cnt - r_vc_inj[w_vc_idx];
        end
    end

    assign w_cmp_dist = hop_distance(w_cmp_sx, w_cmp_sy, current_x, current_y);

    // Free-running timestamp base; latencies are taken modulo its width.
    always_ff @(posedge clk) begin
        if (reset) r_clk_cnt <= {CLK_CNTw{1'b0}};
        else       r_clk_cnt <= r_clk_cnt + CLK_CNTw'(1);
    end

    // Per-VC state register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < V; i++) begin
            if (reset) r_state[i] <= ST_IDLE;
            else       r_state[i] <= w_state_next[i];
        end
    end

    // Per-VC header capture and flit counting.
    always_ff @(posedge clk) begin
        for (int i = 0; i < V; i++) begin
            if (reset) begin
                r_vc_sx[i]   <= {Xw{1'b0}};
                r_vc_sy[i]   <= {Yw{1'b0}};
                r_vc_cls[i]  <= {Cw{1'b0}};
                r_vc_inj[i]  <= {CLK_CNTw{1'b0}};
                r_vc_hdr[i]  <= {CLK_CNTw{1'b0}};
                r_vc_size[i] <= {PCK_SIZw{1'b0}};
            end else if (w_capture[i]) begin
                r_vc_sx[i]   <= w_hdr_sx;
                r_vc_sy[i]   <= w_hdr_sy;
                r_vc_cls[i]  <= w_hdr_cls;
                r_vc_inj[i]  <= w_hdr_ts;
                r_vc_hdr[i]  <= r_clk_cnt;
                r_vc_size[i] <= PCK_SIZw'(1);
            end else if (w_grow[i]) begin
                r_vc_size[i] <= size_inc(r_vc_size[i]);
            end
        end
    end

    // Credit/update pulses, held completion report, packet counter and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit  <= {V{1'b0}};
            r_update  <= 1'b0;
            r_src_x   <= {Xw{1'b0}};
            r_src_y   <= {Yw{1'b0}};
            r_class   <= {Cw{1'b0}};
            r_dist    <= {DSTw{1'b0}};
            r_size    <= {PCK_SIZw{1'b0}};
            r_h2h     <= {CLK_CNTw{1'b0}};
            r_h2t     <= {CLK_CNTw{1'b0}};
            r_rcv_cnt <= {PCK_CNTw{1'b0}};
            r_err     <= 1'b0;
        end else begin
            r_credit <= (flit_in_wr && w_vc_onehot) ? w_vc_field : {V{1'b0}};
            r_update <= w_done;
            if (w_done) begin
                r_src_x   <= w_cmp_sx;
                r_src_y   <= w_cmp_sy;
                r_class   <= w_cmp_cls;
                r_dist    <= w_cmp_dist;
                r_size    <= w_cmp_size;
                r_h2h     <= w_cmp_h2h;
                r_h2t     <= w_cmp_h2t;
                r_rcv_cnt <= (r_rcv_cnt >= CNT_MAX) ? CNT_MAX : r_rcv_cnt + PCK_CNTw'(1);
            end
            if (w_err) r_err <= 1'b1;
        end
    end

    assign credit_out     = r_credit;
    assign update         = r_update;
    assign src_x          = r_src_x;
    assign src_y          = r_src_y;
    assign pck_class_out  = r_class;
    assign distance       = r_dist;
    assign pck_size_out   = r_size;
    assign time_stamp_h2h = r_h2h;
    assign time_stamp_h2t = r_h2t;
    assign rcv_pck_number = r_rcv_cnt;
    assign protocol_err   = r_err;

endmodule

// File: tb/tb_traffic_sink.sv
// Bench for traffic_sink: a MESH instance checked every cycle against a
// packet-level model, plus a small-clock TORUS instance for distance and
// timestamp wrap, with literal expectations on the directed scenarios.
module tb_traffic_sink;

    localparam int V    = 2;
    localparam int FPAY = 32;
    localparam int FW   = 2 + V + FPAY;
    localparam int MODA = 131072;   // 2^17 timestamp range of instance A

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: MESH, current (2,1)
    logic [1:0]    cx_a = 2'd2;
    logic [1:0]    cy_a = 2'd1;
    logic [FW-1:0] flit_a = '0;
    logic          wr_a = 1'b0;
    logic [1:0]    credit_a;
    logic          upd_a;
    logic [1:0]    sx_a, sy_a, cls_a;
    logic [4:0]    dist_a, size_a;
    logic [16:0]   h2h_a, h2t_a;
    logic [13:0]   cnt_a;
    logic          err_a;

    // Instance B: TORUS with a 7-bit timestamp, current (0,1)
    logic [1:0]    cx_b = 2'd0;
    logic [1:0]    cy_b = 2'd1;
    logic [FW-1:0] flit_b = '0;
    logic          wr_b = 1'b0;
    logic [1:0]    credit_b;
    logic          upd_b;
    logic [1:0]    sx_b, sy_b, cls_b;
    logic [4:0]    dist_b, size_b;
    logic [6:0]    h2h_b, h2t_b;
    logic [13:0]   cnt_b;
    logic          err_b;

    traffic_sink #(.V(V), .NX(4), .NY(4), .Fpay(FPAY), .C(4), .TOPOLOGY("MESH")) dut_a (
        .clk(clk), .reset(reset), .current_x(cx_a), .current_y(cy_a),
        .flit_in(flit_a), .flit_in_wr(wr_a), .credit_out(credit_a), .update(upd_a),
        .src_x(sx_a), .src_y(sy_a), .pck_class_out(cls_a), .distance(dist_a),
        .pck_size_out(size_a), .time_stamp_h2h(h2h_a), .time_stamp_h2t(h2t_a),
        .rcv_pck_number(cnt_a), .protocol_err(err_a));

    traffic_sink #(.V(V), .NX(4), .NY(4), .Fpay(FPAY), .C(4), .TOPOLOGY("TORUS"),
                   .MAX_SIM_CLKs(100)) dut_b (
        .clk(clk), .reset(reset), .current_x(cx_b), .current_y(cy_b),
        .flit_in(flit_b), .flit_in_wr(wr_b), .credit_out(credit_b), .update(upd_b),
        .src_x(sx_b), .src_y(sy_b), .pck_class_out(cls_b), .distance(dist_b),
        .pck_size_out(size_b), .time_stamp_h2h(h2h_b), .time_stamp_h2t(h2t_b),
        .rcv_pck_number(cnt_b), .protocol_err(err_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] mk_flit(input logic hdr, input logic tail,
        input logic [1:0] vc, input int sx, input int sy, input int cls, input int ts);
        logic [FPAY-1:0] pay;
        if (hdr) begin
            pay        = '0;
            pay[1:0]   = sx[1:0];
            pay[3:2]   = sy[1:0];
            pay[5:4]   = cls[1:0];
            pay[22:6]  = ts[16:0];
        end else begin
            pay = $urandom;
        end
        return {hdr, tail, vc, pay};
    endfunction

    // ---------------- packet-level model of instance A ----------------
    int m_cnt = 0;
    int m_len [2];
    int m_sx [2], m_sy [2], m_cls [2], m_inj [2], m_hdr_t [2];
    logic [1:0] e_credit = 2'b00;
    logic       e_upd = 1'b0;
    logic       e_err = 1'b0;
    int e_sx = 0, e_sy = 0, e_cls = 0, e_dist = 0, e_size = 0, e_h2h = 0, e_h2t = 0, e_cnt = 0;

    function automatic int wrapm(input int x);
        return ((x % MODA) + MODA) % MODA;
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_complete(input int v);
        e_upd  = 1'b1;
        e_sx   = m_sx[v];
        e_sy   = m_sy[v];
        e_cls  = m_cls[v];
        e_size = (m_len[v] > 16) ? 16 : m_len[v];
        e_h2h  = wrapm(m_hdr_t[v] - m_inj[v]);
        e_h2t  = wrapm(m_cnt - m_inj[v]);
        e_dist = absd(m_sx[v], 2) + absd(m_sy[v], 1);
        e_cnt  = (e_cnt >= 10000) ? 10000 : e_cnt + 1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            e_credit = 2'b00;
            e_upd    = 1'b0;
            if (reset) begin
                m_cnt = 0;
                for (int i = 0; i < 2; i++) m_len[i] = 0;
                e_err = 1'b0; e_sx = 0; e_sy = 0; e_cls = 0; e_dist = 0;
                e_size = 0; e_h2h = 0; e_h2t = 0; e_cnt = 0;
            end else begin
                if (wr_a) begin
                    if (flit_a[33:32] == 2'b01 || flit_a[33:32] == 2'b10) begin
                        int v;
                        v = (flit_a[33:32] == 2'b10) ? 1 : 0;
                        e_credit = flit_a[33:32];
                        if (flit_a[35]) begin
                            if (m_len[v] != 0) e_err = 1'b1;
                            m_sx[v] = flit_a[1:0]; m_sy[v] = flit_a[3:2];
                            m_cls[v] = flit_a[5:4]; m_inj[v] = flit_a[22:6];
                            m_hdr_t[v] = m_cnt; m_len[v] = 1;
                            if (flit_a[34]) begin model_complete(v); m_len[v] = 0; end
                        end else if (m_len[v] == 0) begin
                            e_err = 1'b1;
                        end else begin
                            m_len[v]++;
                            if (flit_a[34]) begin model_complete(v); m_len[v] = 0; end
                        end
                    end else begin
                        e_err = 1'b1;
                    end
                end
                m_cnt = (m_cnt + 1) % MODA;
            end
        end
    end

    // Every-cycle comparison of instance A against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("credit", credit_a, e_credit);
            check("update", upd_a, e_upd);
            check("src_x", sx_a, e_sx);
            check("src_y", sy_a, e_sy);
            check("class", cls_a, e_cls);
            check("distance", dist_a, e_dist);
            check("size", size_a, e_size);
            check("h2h", h2h_a, e_h2h);
            check("h2t", h2t_a, e_h2t);
            check("rcv_cnt", cnt_a, e_cnt);
            check("perr", err_a, e_err);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_reset();
        reset = 1'b1; wr_a = 1'b0; wr_b = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        int guard;
        guard = 0;
        while (m_cnt != target && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (m_cnt != target) check("wait_cnt_timeout", m_cnt, target);
    endtask

    task automatic send_a(input logic [FW-1:0] f);
        flit_a = f; wr_a = 1'b1;
        @(negedge clk);
        wr_a = 1'b0;
    endtask

    task automatic send_b(input logic [FW-1:0] f);
        flit_b = f; wr_b = 1'b1;
        @(negedge clk);
        wr_b = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_credit", credit_a, 32'd0);
        check("rst_update", upd_a, 32'd0);
        check("rst_perr", err_a, 32'd0);
        check("rst_cnt", cnt_a, 32'd0);
        check("rst_b_credit", credit_b, 32'd0);

        // Single-flit packet at clk_cnt 12
        wait_cnt(12);
        send_a(mk_flit(1'b1, 1'b1, 2'b01, 0, 3, 1, 5));
        check("t1_credit", credit_a, 32'd1);
        check("t1_update", upd_a, 32'd1);
        check("t1_h2h", h2h_a, 32'd7);
        check("t1_h2t", h2t_a, 32'd7);
        check("t1_size", size_a, 32'd1);
        check("t1_dist", dist_a, 32'd4);
        check("t1_class", cls_a, 32'd1);
        check("t1_src_y", sy_a, 32'd3);

        // 4-flit packet on VC1, header at 20, tail at 23
        wait_cnt(20);
        send_a(mk_flit(1'b1, 1'b0, 2'b10, 3, 0, 2, 18));
        check("t2_credit0", credit_a, 32'd2);
        for (int i = 0; i < 2; i++) begin
            send_a(mk_flit(1'b0, 1'b0, 2'b10, 0, 0, 0, 0));
            check("t2_credit_body", credit_a, 32'd2);
            check("t2_no_update", upd_a, 32'd0);
        end
        send_a(mk_flit(1'b0, 1'b1, 2'b10, 0, 0, 0, 0));
        check("t2_credit3", credit_a, 32'd2);
        check("t2_update", upd_a, 32'd1);
        check("t2_h2h", h2h_a, 32'd2);
        check("t2_h2t", h2t_a, 32'd5);
        check("t2_size", size_a, 32'd4);
        check("t2_dist", dist_a, 32'd2);
        check("t2_cnt", cnt_a, 32'd2);

        // Injection timestamp near the top of the range
        do_reset();
        wait_cnt(4);
        send_a(mk_flit(1'b1, 1'b1, 2'b01, 2, 1, 0, MODA - 3));
        check("wrap_h2t", h2t_a, 32'd7);
        check("wrap_dist", dist_a, 32'd0);

        // Interleaved 3-flit packets on VC0/VC1
        do_reset();
        send_a(mk_flit(1'b1, 1'b0, 2'b01, 1, 1, 0, 0));
        send_a(mk_flit(1'b1, 1'b0, 2'b10, 3, 3, 3, 0));
        send_a(mk_flit(1'b0, 1'b0, 2'b01, 0, 0, 0, 0));
        send_a(mk_flit(1'b0, 1'b0, 2'b10, 0, 0, 0, 0));
        send_a(mk_flit(1'b0, 1'b1, 2'b01, 0, 0, 0, 0));
        check("il_upd0", upd_a, 32'd1);
        check("il_sx0", sx_a, 32'd1);
        check("il_h2t0", h2t_a, 32'd4);
        check("il_size0", size_a, 32'd3);
        send_a(mk_flit(1'b0, 1'b1, 2'b10, 0, 0, 0, 0));
        check("il_upd1", upd_a, 32'd1);
        check("il_sx1", sx_a, 32'd3);
        check("il_cls1", cls_a, 32'd3);
        check("il_h2h1", h2h_a, 32'd1);
        check("il_h2t1", h2t_a, 32'd5);
        check("il_dist1", dist_a, 32'd3);
        check("il_cnt", cnt_a, 32'd2);
        check("il_perr", err_a, 32'd0);

        // Protocol errors
        send_a(mk_flit(1'b0, 1'b0, 2'b01, 0, 0, 0, 0));
        check("err_body_credit", credit_a, 32'd1);
        check("err_body_upd", upd_a, 32'd0);
        check("err_body_perr", err_a, 32'd1);
        send_a(mk_flit(1'b1, 1'b1, 2'b11, 1, 1, 1, 1));
        check("err_vc11_credit", credit_a, 32'd0);
        check("err_vc11_upd", upd_a, 32'd0);
        send_a(mk_flit(1'b1, 1'b1, 2'b00, 1, 1, 1, 1));
        check("err_vc00_credit", credit_a, 32'd0);
        check("err_cnt_hold", cnt_a, 32'd2);

        // 18-flit packet saturates the size at 16
        send_a(mk_flit(1'b1, 1'b0, 2'b10, 2, 2, 2, 0));
        for (int i = 0; i < 16; i++) send_a(mk_flit(1'b0, 1'b0, 2'b10, 0, 0, 0, 0));
        send_a(mk_flit(1'b0, 1'b1, 2'b10, 0, 0, 0, 0));
        check("long_size", size_a, 32'd16);
        check("long_perr_sticky", err_a, 32'd1);

        // Reset one cycle after a header, with a flit in the reset cycle
        do_reset();
        check("mid_perr_clr", err_a, 32'd0);
        send_a(mk_flit(1'b1, 1'b0, 2'b01, 3, 3, 1, 0));
        reset = 1'b1;
        flit_a = mk_flit(1'b0, 1'b0, 2'b01, 0, 0, 0, 0);
        wr_a = 1'b1;
        @(negedge clk);
        reset = 1'b0; wr_a = 1'b0;
        check("mid_credit_supp", credit_a, 32'd0);
        send_a(mk_flit(1'b0, 1'b1, 2'b01, 0, 0, 0, 0));
        check("mid_no_update", upd_a, 32'd0);
        check("mid_perr", err_a, 32'd1);
        check("mid_credit", credit_a, 32'd1);

        // TORUS distance and 7-bit clock wrap on instance B
        do_reset();
        wait_cnt(125);
        send_b(mk_flit(1'b1, 1'b0, 2'b01, 3, 1, 2, 125));
        check("b_hdr_credit", credit_b, 32'd1);
        wait_cnt(132);
        send_b(mk_flit(1'b0, 1'b1, 2'b01, 0, 0, 0, 0));
        check("b_update", upd_b, 32'd1);
        check("b_dist", dist_b, 32'd1);
        check("b_h2h", h2h_b, 32'd0);
        check("b_h2t", h2t_b, 32'd7);
        check("b_size", size_b, 32'd2);
        check("b_src_x", sx_b, 32'd3);
        check("b_perr", err_b, 32'd0);

        // Packet counter saturation
        do_reset();
        for (int i = 0; i < 10003; i++) send_a(mk_flit(1'b1, 1'b1, 2'b01, 0, 0, 1, 0));
        check("cnt_sat", cnt_a, 32'd10000);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
